// File: rtl/segre_memory.sv
// segre_memory: unified instruction/data memory model with fixed request latency.
// Optional build macro SEGRE_MEM_ALIGN_CHECK_EN enables misaligned-access detection on err_o.
package segre_memory_pkg;
   typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memop_data_type_e;
endpackage

// state | meaning
// IDLE  | no request pending
// BUSY  | request captured, latency counter running
// RESP  | ready_o high for one cycle
module segre_memory
   import segre_memory_pkg::*;
#(
   parameter int ADDR_SIZE   = 32,
   parameter int WORD_SIZE   = 32,
   parameter int DEPTH_WORDS = 4096,
   parameter int LATENCY     = 2
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic [ADDR_SIZE-1:0] addr_i,
   input  logic                 mem_rd_i,
   input  logic                 mem_wr_i,
   input  memop_data_type_e     data_type_i,
   input  logic [WORD_SIZE-1:0] wr_data_i,
   output logic [WORD_SIZE-1:0] rd_data_o,
   output logic                 ready_o,
   output logic                 err_o
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   logic [1:0]           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [IDX_W+1:0]     addr_q;
   memop_data_type_e     type_q;
   logic [WORD_SIZE-1:0] wdata_q;
   logic                 wr_q;
   logic [WORD_SIZE-1:0] rd_data_q;
   logic                 err_q;
   logic                 req, accept, commit;

   logic                 use_in;
   logic [IDX_W+1:0]     op_addr;
   memop_data_type_e     op_type;
   logic [WORD_SIZE-1:0] op_wdata;
   logic                 op_wr;
   logic [IDX_W-1:0]     op_idx;
   logic [WORD_SIZE-1:0] cur_word, merged_word, read_word;
   logic                 misaligned;
   logic                 unused_addr_bits;

   logic [WORD_SIZE-1:0] mem_q [DEPTH_WORDS];

   assign req              = mem_rd_i | mem_wr_i;
   assign unused_addr_bits = ^addr_i[ADDR_SIZE-1:IDX_W+2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  state_d = RESP;
                  commit  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         BUSY: begin
            // terminal count: this edge takes the counter to zero
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
               commit  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With LATENCY=1 the commit happens on the acceptance edge, straight from the pins.
   assign use_in   = (state_q == IDLE);
   assign op_addr  = use_in ? addr_i[IDX_W+1:0] : addr_q;
   assign op_type  = use_in ? data_type_i : type_q;
   assign op_wdata = use_in ? wr_data_i : wdata_q;
   assign op_wr    = use_in ? mem_wr_i : wr_q;
   assign op_idx   = op_addr[IDX_W+1:2];

   always_comb begin
      cur_word    = mem_q[op_idx];
      merged_word = cur_word;
      read_word   = cur_word;
      case (op_type)
         BYTE: begin
            merged_word[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
            read_word = WORD_SIZE'(cur_word[{op_addr[1:0], 3'b000} +: 8]);
         end
         HALF: begin
            merged_word[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
            read_word = WORD_SIZE'(cur_word[{op_addr[1], 4'b0000} +: 16]);
         end
         default: begin
            merged_word = op_wdata;
            read_word   = cur_word;
         end
      endcase
   end

`ifdef SEGRE_MEM_ALIGN_CHECK_EN
   assign misaligned = ((op_type == HALF) && op_addr[0]) ||
                       ((op_type == WORD) && (op_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         type_q    <= BYTE;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= addr_i[IDX_W+1:0];
            type_q  <= data_type_i;
            wdata_q <= wr_data_i;
            wr_q    <= mem_wr_i;
         end
         if (commit) rd_data_q <= (op_wr || misaligned) ? '0 : read_word;
         err_q <= commit & misaligned;
      end
   end

   // Array is deliberately not reset; a reset during BUSY never reaches commit.
   always_ff @(posedge clk_i) begin
      if (commit && op_wr && !misaligned) mem_q[op_idx] <= merged_word;
   end

   assign ready_o   = (state_q == RESP);
   assign rd_data_o = rd_data_q;
   assign err_o     = err_q;
endmodule

// File: tb/tb_segre_memory.sv
// Self-checking bench for segre_memory against a byte-addressed reference model.
module tb_segre_memory;
   import segre_memory_pkg::*;

   localparam int LAT   = 2;
   localparam int BYTES = 4 * 4096;
`ifdef SEGRE_MEM_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rsn;
   logic [31:0]      addr, wdata, rd_data;
   logic             mem_rd, mem_wr, ready, err;
   memop_data_type_e dt;

   int checks = 0;
   int passes = 0;

   logic [7:0] ref_mem [BYTES];
   bit         ref_ok  [BYTES];

   always #5 clk = ~clk;

   segre_memory #(.LATENCY(LAT)) dut (
      .clk_i(clk), .rsn_i(rsn), .addr_i(addr), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
      .data_type_i(dt), .wr_data_i(wdata), .rd_data_o(rd_data), .ready_o(ready), .err_o(err)
   );

   function automatic int nbytes(memop_data_type_e t);
      if (t == BYTE) return 1;
      if (t == HALF) return 2;
      return 4;
   endfunction

   function automatic bit is_mis(logic [31:0] a, memop_data_type_e t);
      return (a % nbytes(t)) != 0;
   endfunction

   function automatic int base_of(logic [31:0] a, memop_data_type_e t);
      int b = int'(a % BYTES);
      return b - (b % nbytes(t));
   endfunction

   function automatic bit exp_err(logic [31:0] a, memop_data_type_e t);
      return ALIGN_CHK && is_mis(a, t);
   endfunction

   task automatic model_write(input logic [31:0] a, input memop_data_type_e t, input logic [31:0] wd);
      int b = base_of(a, t);
      if (exp_err(a, t)) return;
      for (int i = 0; i < nbytes(t); i++) begin
         ref_mem[b+i] = 8'((wd >> (8*i)) & 32'hFF);
         ref_ok[b+i]  = 1'b1;
      end
   endtask

   task automatic model_read(input logic [31:0] a, input memop_data_type_e t,
                             output logic [31:0] d, output bit known);
      int b = base_of(a, t);
      d = 32'h0;
      known = 1'b1;
      if (exp_err(a, t)) return;
      for (int i = 0; i < nbytes(t); i++) begin
         if (!ref_ok[b+i]) known = 1'b0;
         d = d | (32'(ref_mem[b+i]) << (8*i));
      end
   endtask

   // Drives one request, scrambles the pins after acceptance, and measures the ready pulse.
   task automatic access(input logic rd, input logic wr, input memop_data_type_e t,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rdat, output logic er, output int lat, output logic dbl);
      @(negedge clk);
      mem_rd = rd; mem_wr = wr; dt = t; addr = a; wdata = wd;
      @(posedge clk); #1;
      mem_rd = 1'b0; mem_wr = 1'b0;
      addr = $urandom; wdata = $urandom; dt = memop_data_type_e'($urandom_range(0, 2));
      lat = 0; rdat = 'x; er = 1'bx;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk);
         if (ready) begin lat = k; rdat = rd_data; er = err; end
      end
      @(negedge clk);
      dbl = ready;
   endtask

   task automatic test_reset();
      rsn = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0; dt = WORD;
      repeat (3) @(negedge clk);
      checks++; if (ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready); else passes++;
      checks++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data got %h exp 0", rd_data); else passes++;
      checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passes++;
      rsn = 1'b1;
   endtask

   task automatic test_word();
      logic [31:0] r, exp; logic e, d; int l; bit kn;
      access(1'b0, 1'b1, WORD, 32'h100, 32'hDEADBEEF, r, e, l, d);
      model_write(32'h100, WORD, 32'hDEADBEEF);
      checks++; if (l !== LAT) $display("FAIL word_wr_latency got %0d exp %0d", l, LAT); else passes++;
      checks++; if (r !== 32'h0) $display("FAIL word_wr_rd_data got %h exp 0", r); else passes++;
      access(1'b1, 1'b0, WORD, 32'h100, 32'h0, r, e, l, d);
      model_read(32'h100, WORD, exp, kn);
      checks++; if (l !== LAT) $display("FAIL word_rd_latency got %0d exp %0d", l, LAT); else passes++;
      checks++; if (r !== exp) $display("FAIL word_rd_data got %h exp %h", r, exp); else passes++;
      checks++; if (d !== 1'b0) $display("FAIL word_ready_single got %b exp 0", d); else passes++;
   endtask

   task automatic test_lanes();
      logic [31:0] r, exp; logic e, d; int l; bit kn;
      access(1'b0, 1'b1, WORD, 32'h40, 32'h11223344, r, e, l, d); model_write(32'h40, WORD, 32'h11223344);
      access(1'b0, 1'b1, BYTE, 32'h42, 32'hFFFFFFAA, r, e, l, d); model_write(32'h42, BYTE, 32'hFFFFFFAA);
      access(1'b1, 1'b0, WORD, 32'h40, 32'h0, r, e, l, d); model_read(32'h40, WORD, exp, kn);
      checks++; if (r !== exp) $display("FAIL lane_word got %h exp %h", r, exp); else passes++;
      access(1'b1, 1'b0, HALF, 32'h42, 32'h0, r, e, l, d); model_read(32'h42, HALF, exp, kn);
      checks++; if (r !== exp) $display("FAIL lane_half got %h exp %h", r, exp); else passes++;
      access(1'b1, 1'b0, BYTE, 32'h43, 32'h0, r, e, l, d); model_read(32'h43, BYTE, exp, kn);
      checks++; if (r !== exp) $display("FAIL lane_byte got %h exp %h", r, exp); else passes++;
   endtask

   task automatic test_back_to_back_hold();
      logic [31:0] r, r1, r2, e1, e2; logic e, d; int l; bit kn;
      access(1'b0, 1'b1, WORD, 32'h200, 32'h13579BDF, r, e, l, d); model_write(32'h200, WORD, 32'h13579BDF);
      model_read(32'h100, WORD, e1, kn);
      model_read(32'h200, WORD, e2, kn);
      r1 = '0; r2 = '0;
      @(negedge clk);
      mem_rd = 1'b1; dt = WORD; addr = 32'h100;
      @(posedge clk); #1;
      addr = 32'h200;
      for (int k = 1; k <= 2*LAT+1; k++) begin
         @(negedge clk);
         checks++;
         if (ready !== ((k == LAT) || (k == 2*LAT+1)))
            $display("FAIL hold_ready_k%0d got %b exp %b", k, ready, (k == LAT) || (k == 2*LAT+1));
         else passes++;
         if (k == LAT) r1 = rd_data;
         if (k == LAT+2) mem_rd = 1'b0;
         if (k == 2*LAT+1) r2 = rd_data;
      end
      checks++; if (r1 !== e1) $display("FAIL hold_first_data got %h exp %h", r1, e1); else passes++;
      checks++; if (r2 !== e2) $display("FAIL hold_second_data got %h exp %h", r2, e2); else passes++;
      @(negedge clk);
   endtask

   task automatic test_wrap();
      logic [31:0] r, exp; logic e, d; int l; bit kn;
      access(1'b0, 1'b1, WORD, 32'h4000, 32'h5A5A5A5A, r, e, l, d); model_write(32'h4000, WORD, 32'h5A5A5A5A);
      access(1'b1, 1'b0, WORD, 32'h0, 32'h0, r, e, l, d); model_read(32'h0, WORD, exp, kn);
      checks++; if (r !== exp) $display("FAIL wrap_data got %h exp %h", r, exp); else passes++;
   endtask

   task automatic test_rd_wr_both();
      logic [31:0] r, exp; logic e, d; int l; bit kn;
      access(1'b1, 1'b1, WORD, 32'h300, 32'h0BADC0DE, r, e, l, d); model_write(32'h300, WORD, 32'h0BADC0DE);
      checks++; if (r !== 32'h0) $display("FAIL both_rd_data got %h exp 0", r); else passes++;
      access(1'b1, 1'b0, WORD, 32'h300, 32'h0, r, e, l, d); model_read(32'h300, WORD, exp, kn);
      checks++; if (r !== exp) $display("FAIL both_readback got %h exp %h", r, exp); else passes++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] r, exp; logic e, d; int l; bit kn;
      access(1'b0, 1'b1, WORD, 32'h80, 32'h0, r, e, l, d); model_write(32'h80, WORD, 32'h0);
      access(1'b1, 1'b0, WORD, 32'h100, 32'h0, r, e, l, d);
      @(negedge clk);
      mem_wr = 1'b1; dt = WORD; addr = 32'h80; wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      mem_wr = 1'b0; rsn = 1'b0;
      #1;
      checks++; if (rd_data !== 32'h0) $display("FAIL rstmid_rd_data got %h exp 0", rd_data); else passes++;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 2) rsn = 1'b1;
         checks++; if (ready !== 1'b0) $display("FAIL rstmid_ready_k%0d got %b exp 0", k, ready); else passes++;
      end
      access(1'b1, 1'b0, WORD, 32'h80, 32'h0, r, e, l, d); model_read(32'h80, WORD, exp, kn);
      checks++; if (r !== exp) $display("FAIL rstmid_readback got %h exp %h", r, exp); else passes++;
   endtask

   task automatic test_misaligned();
      logic [31:0] r, exp; logic e, d; int l; bit kn;
      access(1'b0, 1'b1, WORD, 32'h102, 32'hFFFFFFFF, r, e, l, d); model_write(32'h102, WORD, 32'hFFFFFFFF);
      checks++; if (e !== exp_err(32'h102, WORD)) $display("FAIL mis_wr_err got %b exp %b", e, exp_err(32'h102, WORD)); else passes++;
      checks++; if (l !== LAT) $display("FAIL mis_wr_latency got %0d exp %0d", l, LAT); else passes++;
      access(1'b1, 1'b0, WORD, 32'h100, 32'h0, r, e, l, d); model_read(32'h100, WORD, exp, kn);
      checks++; if (r !== exp) $display("FAIL mis_word_check got %h exp %h", r, exp); else passes++;
      access(1'b1, 1'b0, HALF, 32'h101, 32'h0, r, e, l, d); model_read(32'h101, HALF, exp, kn);
      checks++; if (r !== exp) $display("FAIL mis_half_rd got %h exp %h", r, exp); else passes++;
      checks++; if (e !== exp_err(32'h101, HALF)) $display("FAIL mis_half_err got %b exp %b", e, exp_err(32'h101, HALF)); else passes++;
   endtask

   task automatic test_random();
      logic [31:0] a, wd, r, exp; logic e, d, rd, wr; int l; bit kn; memop_data_type_e t;
      for (int n = 0; n < 60; n++) begin
         a  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
         t  = memop_data_type_e'($urandom_range(0, 2));
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         wd = $urandom;
         model_read(a, t, exp, kn);
         access(rd, wr, t, a, wd, r, e, l, d);
         if (wr) begin model_write(a, t, wd); exp = 32'h0; kn = 1'b1; end
         checks++; if (l !== LAT) $display("FAIL rnd%0d_latency got %0d exp %0d", n, l, LAT); else passes++;
         checks++; if (e !== exp_err(a, t)) $display("FAIL rnd%0d_err got %b exp %b", n, e, exp_err(a, t)); else passes++;
         checks++; if (d !== 1'b0) $display("FAIL rnd%0d_ready_single got %b exp 0", n, d); else passes++;
         if (kn) begin
            checks++; if (r !== exp) $display("FAIL rnd%0d_data a=%h got %h exp %h", n, a, r, exp); else passes++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_lanes();
      test_back_to_back_hold();
      test_wrap();
      test_rd_wr_both();
      test_reset_mid();
      test_misaligned();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
